uart_tx_core: RTL and testbench
===============================

// Module: uart_tx_core
// PURPOSE
//  UART 8N1 transmitter: start bit, 8 data bits LSB first, one stop bit.
//  Combines the transmit FSM, the baud-tick generator and the shift/line driver.
//  Sits between a host that presents bytes with a start strobe and the serial TX pin.
//  Reports busy while a frame is on the line and a one-cycle done pulse at frame end.
// PARAMETERS
//  SCYCLE    50000000  system clock frequency in Hz
//  BAUDRATE  115200    serial bit rate. DIV = SCYCLE/BAUDRATE, integer-truncated (434 at defaults).
// PORTS
//  iCLOCK   in   1  system clock; all logic on the rising edge
//  iRESET   in   1  reset: synchronous, active-high
//  iSTART   in   1  transmit request, level-sampled in IDLE
//  iTXDATA  in   8  byte to send, captured on request acceptance
//  oTXBUSY  out  1  high while a frame is being shifted out
//  oTXDONE  out  1  one-cycle pulse after the stop bit completes
//  oTX      out  1  serial line; idles high
// BEHAVIOUR
//  - Reset (iRESET=1 at an edge), taking effect the next cycle:
//    - state=IDLE, baud counter=0, bit index=0, shift reg=0.
//    - oTX=1, oTXBUSY=0, oTXDONE=0.
//    - Reset mid-frame aborts the frame immediately; no oTXDONE is produced.
//  - FSM, 2-bit state: IDLE=0, SEND=1, DONE=2; code 3 is unused and recovers to IDLE.
//  - IDLE, iSTART=1 at edge T:
//    - latch iTXDATA; go SEND; clear baud counter and bit index.
//    - From T+1: oTX=0 (start bit), oTXBUSY=1.
//  - IDLE, iSTART=0: stay IDLE with oTX=1.
//  - SEND:
//    - baud counter counts 0..DIV-1; a bit tick (bclk) fires when counter==DIV-1, then the counter wraps to 0.
//    - each bclk advances the bit index. Line value per index:
//      - idx 0: start bit, 0
//      - idx 1..8: data[idx-1]
//      - idx 9: stop bit, 1
//    - every bit is held exactly DIV cycles.
//    - bclk with idx==9 raises break; go DONE.
//  - DONE (exactly 1 cycle): oTXDONE=1, oTXBUSY=0, oTX=1; then IDLE.
//  - Timing: oTXDONE is high in cycle T+1+10*DIV; oTXBUSY is high for cycles T+1 .. T+10*DIV.
//  - iSTART while in SEND or DONE is ignored; iTXDATA changes during a frame have no effect.
//  - iSTART held high continuously gives back-to-back frames:
//    - the next frame is accepted on the first IDLE cycle after DONE.
//    - minimum idle-high gap between stop bit end and next start bit is 2 cycles.
//  - Outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared package uart_pkg:
//    - state typedef/localparams IDLE/SEND/DONE
//    - FRAME_BITS=10, DATA_BITS=8
//  - One sub-module uart_tx_baudgen (params SCYCLE, BAUDRATE):
//    - inputs: clock, reset, en (state==SEND), clr (start accepted)
//    - outputs: bclk tick, break (tick on last bit)
//  - FSM, shift register and line driver live in uart_tx_core.
// TESTING
//  1. Reset held 1 cycle, then released -> oTX=1, oTXBUSY=0, oTXDONE=0 and stay so with iSTART=0.
//  2. Send 0xA5, iSTART pulsed 1 cycle:
//     - oTX line reads 0,1,0,1,0,0,1,0,1,1 (LSB first), each bit 434 cycles.
//     - oTXDONE pulses once at T+1+4340.
//  3. Send 0x3C with iSTART held high until oTXDONE:
//     - same frame format; a second frame starts 2 cycles after the stop bit ends.
//     - 3 consecutive frames are all correct.
//  4. Request with iTXDATA changed and iSTART re-pulsed mid-frame -> ignored; the original byte completes unchanged.
//  5. iRESET asserted during data bit 4 -> next cycle oTX=1, oTXBUSY=0; no oTXDONE; a new 0xFF send afterwards is correct.
//  6. Three pulsed frames 0x00, 0xFF, 0x55, each issued 1 cycle after the previous oTXDONE -> all three frames correct, each with exactly 1 done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Purpose : Shared constants for the UART transmitter slice: the 2-bit FSM
//           state encoding, frame geometry and the baud divider calculation.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package uart_pkg;

    // FSM state encoding; code 3 is unused and recovers to IDLE.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t SEND = 2'd1;
    localparam state_t DONE = 2'd2;

    // Frame geometry: start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Width of the bit index register (must hold 0..FRAME_BITS-1).
    localparam int IDX_W = 4;

    // Clock cycles per serial bit, integer-truncated.
    function automatic int baudDiv(input int sCycle, input int baudRate);
        return sCycle / baudRate;
    endfunction

endpackage

// File: rtl/uart_tx_baudgen.sv
// ---------------------------------------------------------------------------
// uart_tx_baudgen
// Purpose : Baud counter for the transmitter. Counts 0..DIV-1 while enabled
//           and emits a one-cycle bit tick when the count reaches DIV-1.
//           When that tick lands on the final (stop) bit it also emits brk_o
//           so the FSM knows the frame is finished.
// Ports   :
//   clock_i  in  1  system clock, rising edge
//   reset_i  in  1  synchronous active-high reset
//   en_i     in  1  count enable (transmitter is in SEND)
//   clr_i    in  1  clear counter (start request accepted)
//   last_i   in  1  current bit is the stop bit
//   bclk_o   out 1  bit tick: current bit has been held DIV cycles
//   brk_o    out 1  bit tick on the last bit of the frame
// ---------------------------------------------------------------------------
module uart_tx_baudgen
    import uart_pkg::*;
#(
    parameter int SCYCLE   = 50000000,
    parameter int BAUDRATE = 115200
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic last_i,
    output logic bclk_o,
    output logic brk_o
);

    localparam int DIV = baudDiv(SCYCLE, BAUDRATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The tick is combinational from the counter so the FSM can act on the
    // same edge that wraps the counter; all outputs of the top stay registered.
    assign bclk_o = en_i && (cnt_q == CNT_MAX);
    assign brk_o  = bclk_o && last_i;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// Purpose : UART 8N1 transmitter. A host presents a byte with iSTART; the
//           core shifts out start bit, 8 data bits LSB first and a stop bit,
//           each held DIV = SCYCLE/BAUDRATE cycles. oTXBUSY is high while the
//           frame is on the line, oTXDONE pulses for one cycle at frame end.
// Ports   :
//   iCLOCK   in  1  system clock, rising edge
//   iRESET   in  1  synchronous active-high reset
//   iSTART   in  1  transmit request, level-sampled in IDLE
//   iTXDATA  in  8  byte to send, captured when the request is accepted
//   oTXBUSY  out 1  frame in progress
//   oTXDONE  out 1  one-cycle pulse after the stop bit completes
//   oTX      out 1  serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int SCYCLE   = 50000000,
    parameter int BAUDRATE = 115200
) (
    input  logic       iCLOCK,
    input  logic       iRESET,
    input  logic       iSTART,
    input  logic [7:0] iTXDATA,
    output logic       oTXBUSY,
    output logic       oTXDONE,
    output logic       oTX
);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic bclk;
    logic brk;
    logic accept;

    assign accept = (state_q == IDLE) && iSTART;

    uart_tx_baudgen #(
        .SCYCLE   (SCYCLE),
        .BAUDRATE (BAUDRATE)
    ) uBaud (
        .clock_i (iCLOCK),
        .reset_i (iRESET),
        .en_i    (state_q == SEND),
        .clr_i   (accept),
        .last_i  (idx_q == IDX_W'(FRAME_BITS - 1)),
        .bclk_o  (bclk),
        .brk_o   (brk)
    );

    // Next-state logic. The line value is registered, so on each bit tick we
    // load the value of the bit that the index is about to advance to: the
    // shift register feeds data bits LSB first, and after the last data bit
    // the line goes high for the stop bit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (iSTART) begin
                    state_d = SEND;
                    shift_d = iTXDATA;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (brk) begin
                    state_d = DONE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (bclk) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q < IDX_W'(DATA_BITS)) begin
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight without
    // producing a done pulse.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oTX     = tx_q;
    assign oTXBUSY = busy_q;
    assign oTXDONE = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
// Purpose : Directed testbench for uart_tx_core at default parameters
//           (DIV = 434 cycles per bit).
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int DIV    = 434;
    localparam int FRAMES = 10;

    logic       clock;
    logic       iRESET;
    logic       iSTART;
    logic [7:0] iTXDATA;
    logic       oTXBUSY;
    logic       oTXDONE;
    logic       oTX;

    int checks;
    int failures;

    uart_tx_core #(
        .SCYCLE   (50000000),
        .BAUDRATE (115200)
    ) dut (
        .iCLOCK  (clock),
        .iRESET  (iRESET),
        .iSTART  (iSTART),
        .iTXDATA (iTXDATA),
        .oTXBUSY (oTXBUSY),
        .oTXDONE (oTXDONE),
        .oTX     (oTX)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observes one frame starting at the falling edge of the first start-bit
    // cycle. Records the line value of each bit slot, whether every slot was
    // stable for DIV cycles with busy high and no early done, then reports the
    // outputs in the cycle right after the stop bit.
    task automatic captureFrame(output logic [9:0] bits, output bit stable,
                                output bit busyAll, output bit doneEarly,
                                output logic doneNow, output logic busyNow,
                                output logic txNow);
        stable    = 1'b1;
        busyAll   = 1'b1;
        doneEarly = 1'b0;
        bits      = '0;
        for (int s = 0; s < FRAMES; s++) begin
            for (int c = 0; c < DIV; c++) begin
                if (c == 0) bits[s] = oTX;
                else if (oTX !== bits[s]) stable = 1'b0;
                if (oTXBUSY !== 1'b1) busyAll = 1'b0;
                if (oTXDONE !== 1'b0) doneEarly = 1'b1;
                @(negedge clock);
            end
        end
        doneNow = oTXDONE;
        busyNow = oTXBUSY;
        txNow   = oTX;
    endtask

    task automatic test_reset;
        bit stayed;
        iRESET  = 1'b1;
        iSTART  = 1'b0;
        iTXDATA = 8'h00;
        @(negedge clock);
        iRESET = 1'b0;
        checks++;
        if (oTX !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_tx actual=%b required=1", oTX);
        end
        checks++;
        if (oTXBUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy actual=%b required=0", oTXBUSY);
        end
        checks++;
        if (oTXDONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_done actual=%b required=0", oTXDONE);
        end
        stayed = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (oTX !== 1'b1 || oTXBUSY !== 1'b0 || oTXDONE !== 1'b0) stayed = 1'b0;
        end
        checks++;
        if (!stayed) begin
            failures++;
            $display("[TB] FAIL reset_idle_hold actual=changed required=idle tx=%b busy=%b done=%b",
                     oTX, oTXBUSY, oTXDONE);
        end
    endtask

    task automatic test_single_a5;
        logic [9:0] bits;
        bit stable, busyAll, doneEarly;
        logic doneNow, busyNow, txNow;
        iTXDATA = 8'hA5;
        iSTART  = 1'b1;
        @(negedge clock);
        iSTART  = 1'b0;
        captureFrame(bits, stable, busyAll, doneEarly, doneNow, busyNow, txNow);
        // line order 0,1,0,1,0,0,1,0,1,1 -> slot i in bit i
        checks++;
        if (bits !== 10'b11_0100_1010) begin
            failures++;
            $display("[TB] FAIL a5_bits actual=%b required=%b", bits, 10'b11_0100_1010);
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("[TB] FAIL a5_bit_width actual=unstable required=%0d_cycles_per_bit", DIV);
        end
        checks++;
        if (!busyAll) begin
            failures++;
            $display("[TB] FAIL a5_busy actual=dropped required=high_whole_frame");
        end
        checks++;
        if (doneEarly) begin
            failures++;
            $display("[TB] FAIL a5_done_early actual=1 required=0");
        end
        checks++;
        if (doneNow !== 1'b1 || busyNow !== 1'b0 || txNow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL a5_done_cycle actual=done%b_busy%b_tx%b required=done1_busy0_tx1",
                     doneNow, busyNow, txNow);
        end
        @(negedge clock);
        checks++;
        if (oTXDONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL a5_done_width actual=%b required=0", oTXDONE);
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_back_to_back;
        logic [9:0] bits;
        bit stable, busyAll, doneEarly;
        logic doneNow, busyNow, txNow;
        iTXDATA = 8'h3C;
        iSTART  = 1'b1;
        @(negedge clock);
        for (int f = 0; f < 3; f++) begin
            captureFrame(bits, stable, busyAll, doneEarly, doneNow, busyNow, txNow);
            if (f == 2) iSTART = 1'b0;
            checks++;
            // 0x3C framed: start 0, 0,0,1,1,1,1,0,0, stop 1
            if (bits !== 10'b10_0111_1000 || !stable || !busyAll || doneEarly) begin
                failures++;
                $display("[TB] FAIL b2b_frame%0d actual=%b stable=%0d busy=%0d early=%0d required=%b",
                         f, bits, stable, busyAll, doneEarly, 10'b10_0111_1000);
            end
            checks++;
            if (doneNow !== 1'b1 || txNow !== 1'b1) begin
                failures++;
                $display("[TB] FAIL b2b_done%0d actual=done%b_tx%b required=done1_tx1",
                         f, doneNow, txNow);
            end
            @(negedge clock);
            checks++;
            if (oTX !== 1'b1 || oTXBUSY !== 1'b0 || oTXDONE !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_gap%0d actual=tx%b_busy%b_done%b required=tx1_busy0_done0",
                         f, oTX, oTXBUSY, oTXDONE);
            end
            @(negedge clock);
            if (f < 2) begin
                checks++;
                if (oTX !== 1'b0 || oTXBUSY !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_restart%0d actual=tx%b_busy%b required=tx0_busy1",
                             f, oTX, oTXBUSY);
                end
            end
        end
        checks++;
        if (oTX !== 1'b1 || oTXBUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_stop actual=tx%b_busy%b required=tx1_busy0", oTX, oTXBUSY);
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_ignore_midframe;
        logic [9:0] bits;
        bit stable, busyAll, doneEarly;
        logic doneNow, busyNow, txNow;
        iTXDATA = 8'h96;
        iSTART  = 1'b1;
        @(negedge clock);
        iSTART  = 1'b0;
        fork
            captureFrame(bits, stable, busyAll, doneEarly, doneNow, busyNow, txNow);
            begin
                repeat (1000) @(negedge clock);
                iTXDATA = 8'h00;
                iSTART  = 1'b1;
                @(negedge clock);
                iSTART  = 1'b0;
                repeat (1500) @(negedge clock);
                iTXDATA = 8'hFF;
            end
        join
        checks++;
        // 0x96 framed: start 0, 0,1,1,0,1,0,0,1, stop 1
        if (bits !== 10'b11_0010_1100 || !stable || !busyAll || doneEarly) begin
            failures++;
            $display("[TB] FAIL ignore_frame actual=%b stable=%0d busy=%0d early=%0d required=%b",
                     bits, stable, busyAll, doneEarly, 10'b11_0010_1100);
        end
        checks++;
        if (doneNow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ignore_done actual=%b required=1", doneNow);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (oTX !== 1'b1 || oTXBUSY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_no_second actual=tx%b_busy%b required=tx1_busy0", oTX, oTXBUSY);
        end
    endtask

    task automatic test_reset_midframe;
        logic [9:0] bits;
        bit stable, busyAll, doneEarly, quiet;
        logic doneNow, busyNow, txNow;
        iTXDATA = 8'hA5;
        iSTART  = 1'b1;
        @(negedge clock);
        iSTART  = 1'b0;
        // move into the middle of data bit 4 (slot 5), which is 0 for 0xA5
        repeat (5 * DIV + 200) @(negedge clock);
        checks++;
        if (oTX !== 1'b0 || oTXBUSY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_before actual=tx%b_busy%b required=tx0_busy1", oTX, oTXBUSY);
        end
        iRESET = 1'b1;
        @(negedge clock);
        iRESET = 1'b0;
        checks++;
        if (oTX !== 1'b1 || oTXBUSY !== 1'b0 || oTXDONE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_after actual=tx%b_busy%b_done%b required=tx1_busy0_done0",
                     oTX, oTXBUSY, oTXDONE);
        end
        quiet = 1'b1;
        for (int i = 0; i < 6 * DIV; i++) begin
            @(negedge clock);
            if (oTXDONE !== 1'b0 || oTX !== 1'b1 || oTXBUSY !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("[TB] FAIL rst_mid_quiet actual=activity required=idle_no_done");
        end
        iTXDATA = 8'hFF;
        iSTART  = 1'b1;
        @(negedge clock);
        iSTART  = 1'b0;
        captureFrame(bits, stable, busyAll, doneEarly, doneNow, busyNow, txNow);
        checks++;
        if (bits !== 10'b11_1111_1110 || !stable || !busyAll || doneEarly || doneNow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_resend actual=%b stable=%0d busy=%0d early=%0d done=%b required=%b",
                     bits, stable, busyAll, doneEarly, doneNow, 10'b11_1111_1110);
        end
        repeat (5) @(negedge clock);
    endtask

    task automatic test_sequence;
        logic [7:0] data [3];
        logic [9:0] want [3];
        logic [9:0] bits;
        bit stable, busyAll, doneEarly;
        logic doneNow, busyNow, txNow;
        data[0] = 8'h00; want[0] = 10'b10_0000_0000;
        data[1] = 8'hFF; want[1] = 10'b11_1111_1110;
        data[2] = 8'h55; want[2] = 10'b10_1010_1010;
        for (int f = 0; f < 3; f++) begin
            iTXDATA = data[f];
            iSTART  = 1'b1;
            @(negedge clock);
            iSTART  = 1'b0;
            captureFrame(bits, stable, busyAll, doneEarly, doneNow, busyNow, txNow);
            checks++;
            if (bits !== want[f] || !stable || !busyAll || doneEarly) begin
                failures++;
                $display("[TB] FAIL seq_frame%0d actual=%b stable=%0d busy=%0d early=%0d required=%b",
                         f, bits, stable, busyAll, doneEarly, want[f]);
            end
            checks++;
            if (doneNow !== 1'b1) begin
                failures++;
                $display("[TB] FAIL seq_done%0d actual=%b required=1", f, doneNow);
            end
            @(negedge clock);
            checks++;
            if (oTXDONE !== 1'b0) begin
                failures++;
                $display("[TB] FAIL seq_done_once%0d actual=%b required=0", f, oTXDONE);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        iRESET   = 1'b1;
        iSTART   = 1'b0;
        iTXDATA  = 8'h00;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
